// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM sram bus arbiter.
// Owner encoding and the packed command layout used to mux the two
// requesters onto the single shared bus.
package sram_bus_arbiter_pkg;

   // Who issued an outstanding transaction; stored in the owner FIFO.
   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_e;

   // sram-like transfer sizes.
   localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
   localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

   // {wr, size, addr, wstrb, wdata}
   localparam int SRAM_CMD_WIDTH = 1 + 2 + 32 + 4 + 32;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } sram_cmd_t;

   // Flatten one requester's command fields so both sides can be muxed as
   // a single vector.
   function automatic logic [SRAM_CMD_WIDTH-1:0] pack_cmd(
      input logic        wr,
      input logic [1:0]  size,
      input logic [31:0] addr,
      input logic [3:0]  wstrb,
      input logic [31:0] wdata
   );
      return {wr, size, addr, wstrb, wdata};
   endfunction

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// In-order record of who owns each issued-but-unreturned bus transaction.
// One bit per entry; head names the requester the next response belongs to.
// Simultaneous push and pop leave the occupancy unchanged.
module sram_bus_arbiter_owner_fifo
   import sram_bus_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  owner_e push_owner,
   input  logic   pop,
   output logic   full,
   output logic   empty,
   output owner_e head
);

   // A depth-1 FIFO has no pointer bits; keep a 1-bit pointer that stays 0.
   localparam int IDX_W = (DEPTH > 1) ? PTR_W : 1;
   localparam int CNT_W = PTR_W + 1;

   owner_e             mem [DEPTH];
   logic [IDX_W-1:0]   wr_ptr_q;
   logic [IDX_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               do_push;
   logic               do_pop;

   // Pointer advance wrapping modulo DEPTH (DEPTH need not fill IDX_W).
   function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] p);
      if (DEPTH == 1) return '0;
      if (p == IDX_W'(DEPTH - 1)) return '0;
      return p + IDX_W'(1);
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem[rd_ptr_q];
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push && (!full || do_pop);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Owner storage; contents are only meaningful between push and pop.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_owner;
   end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like bus between the IF (instruction) and MEM (data)
// requesters. Data wins address arbitration; a request left waiting for
// bus_addr_ok locks the grant so the presented command stays stable.
// Responses are steered back in issue order via the owner FIFO.
module sram_bus_arbiter
   import sram_bus_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int OWNER_PTR_W     = $clog2(MAX_OUTSTANDING)
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,

   output logic        spurious_rsp
);

   logic [SRAM_CMD_WIDTH-1:0] inst_cmd;
   logic [SRAM_CMD_WIDTH-1:0] data_cmd;
   logic [SRAM_CMD_WIDTH-1:0] gnt_cmd;
   sram_cmd_t                 bus_cmd;

   owner_e grant;
   owner_e lock_owner_q;
   logic   lock_q;
   logic   gnt_req;
   logic   issue;
   logic   accept;

   logic   fifo_full;
   logic   fifo_empty;
   owner_e fifo_head;
   logic   rsp_valid;
   logic   spurious_q;

   assign inst_cmd = pack_cmd(inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata);
   assign data_cmd = pack_cmd(data_wr, data_size, data_addr, data_wstrb, data_wdata);

   // Grant selection: a pending lock wins, otherwise data has priority.
   always_comb begin
      grant = OWNER_INST;
      if (lock_q)
         grant = lock_owner_q;
      else if (data_req)
         grant = OWNER_DATA;
      gnt_req = (grant == OWNER_DATA) ? data_req : inst_req;
      gnt_cmd = (grant == OWNER_DATA) ? data_cmd : inst_cmd;
   end

   // Full is a registered count, so bus_data_ok never reaches bus_req
   // combinationally; a pop frees the slot for the following cycle.
   assign issue  = gnt_req && !fifo_full && !reset;
   assign accept = issue && bus_addr_ok;

   assign bus_cmd   = reset ? '0 : sram_cmd_t'(gnt_cmd);
   assign bus_req   = issue;
   assign bus_wr    = bus_cmd.wr;
   assign bus_size  = bus_cmd.size;
   assign bus_addr  = bus_cmd.addr;
   assign bus_wstrb = bus_cmd.wstrb;
   assign bus_wdata = bus_cmd.wdata;

   assign inst_addr_ok = accept && (grant == OWNER_INST);
   assign data_addr_ok = accept && (grant == OWNER_DATA);

   // A response only belongs to someone if a transaction is outstanding.
   assign rsp_valid    = bus_data_ok && !fifo_empty && !reset;
   assign inst_data_ok = rsp_valid && (fifo_head == OWNER_INST);
   assign data_data_ok = rsp_valid && (fifo_head == OWNER_DATA);
   assign inst_rdata   = reset ? '0 : bus_rdata;
   assign data_rdata   = reset ? '0 : bus_rdata;

   assign spurious_rsp = spurious_q && !reset;

   // Hold the grant on a requester whose address phase is still waiting.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q       <= 1'b0;
         lock_owner_q <= OWNER_INST;
      end else if (issue && !bus_addr_ok) begin
         lock_q       <= 1'b1;
         lock_owner_q <= grant;
      end else if (accept) begin
         lock_q       <= 1'b0;
      end
   end

   // Sticky flag for a bus response that nobody was waiting for.
   always_ff @(posedge clk) begin
      if (reset)
         spurious_q <= 1'b0;
      else if (bus_data_ok && fifo_empty)
         spurious_q <= 1'b1;
   end

   sram_bus_arbiter_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .PTR_W (OWNER_PTR_W)
   ) u_owner_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (accept),
      .push_owner (grant),
      .pop        (rsp_valid),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (fifo_head)
   );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with an in-order owner scoreboard.
module tb_sram_bus_arbiter;
   import sram_bus_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok, bus_data_ok;
   logic [31:0] bus_rdata;
   logic        spurious_rsp;

   int     errors = 0;
   int     checks = 0;
   owner_e exp_q[$];

   always #5 clk = ~clk;

   sram_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_wstrb   (inst_wstrb),
      .inst_wdata   (inst_wdata),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .bus_req      (bus_req),
      .bus_wr       (bus_wr),
      .bus_size     (bus_size),
      .bus_addr     (bus_addr),
      .bus_wstrb    (bus_wstrb),
      .bus_wdata    (bus_wdata),
      .bus_addr_ok  (bus_addr_ok),
      .bus_data_ok  (bus_data_ok),
      .bus_rdata    (bus_rdata),
      .spurious_rsp (spurious_rsp)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_req = 1'b0; inst_wr = 1'b0; inst_size = SRAM_SIZE_WORD;
      inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
      data_req = 1'b0; data_wr = 1'b0; data_size = SRAM_SIZE_WORD;
      data_addr = '0; data_wstrb = '0; data_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
   endtask

   // Compare one response (already driven, sampled now) against the head.
   task automatic rsp_check(input string tag, input logic [31:0] rd);
      owner_e o;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      o = exp_q.pop_front();
      check({tag, "_inst_ok"}, inst_data_ok, o == OWNER_INST);
      check({tag, "_data_ok"}, data_data_ok, o == OWNER_DATA);
      check({tag, "_rdata"}, (o == OWNER_INST) ? inst_rdata : data_rdata, rd);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr_ok"}, {inst_addr_ok, data_addr_ok}, 0);
      check({tag, "_data_ok"}, {inst_data_ok, data_data_ok}, 0);
      check({tag, "_rdata"}, {inst_rdata, data_rdata}, 0);
      check({tag, "_bus_ctl"}, {bus_req, bus_wr, bus_size, bus_wstrb}, 0);
      check({tag, "_bus_addr"}, {bus_addr, bus_wdata}, 0);
      check({tag, "_spurious"}, spurious_rsp, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b1;
      // Reset with every input active: all outputs must stay 0.
      inst_req = 1'b1; inst_addr = 32'h1c00_0000; inst_size = SRAM_SIZE_HALF;
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1c00_0100;
      data_wstrb = 4'hf; data_wdata = 32'h1234_5678; data_size = SRAM_SIZE_BYTE;
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hffff_ffff;
      @(negedge clk);
      check_reset_outputs("rst");
      tick(); tick();
      idle();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_bus_req", bus_req, 0);
      check("post_rst_spurious", spurious_rsp, 0);

      // Simultaneous requests: data first, inst next cycle.
      tick();
      data_req = 1'b1; data_addr = 32'h1c00_0100;
      inst_req = 1'b1; inst_addr = 32'h1c00_0000;
      bus_addr_ok = 1'b1;
      @(negedge clk);
      check("sim_data_addr_ok", data_addr_ok, 1);
      check("sim_inst_addr_ok0", inst_addr_ok, 0);
      check("sim_bus_addr0", bus_addr, 32'h1c00_0100);
      if (data_addr_ok) exp_q.push_back(OWNER_DATA);
      tick();
      data_req = 1'b0;
      @(negedge clk);
      check("sim_inst_addr_ok1", inst_addr_ok, 1);
      check("sim_bus_addr1", bus_addr, 32'h1c00_0000);
      if (inst_addr_ok) exp_q.push_back(OWNER_INST);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b0;
      // In-order return routing.
      bus_data_ok = 1'b1; bus_rdata = 32'haaaa_5555;
      @(negedge clk);
      rsp_check("ord0", 32'haaaa_5555);
      tick();
      bus_rdata = 32'h1234_5678;
      @(negedge clk);
      rsp_check("ord1", 32'h1234_5678);
      tick();
      bus_data_ok = 1'b0;

      // Lock: inst waits 3 cycles, data rises on cycle 1.
      inst_req = 1'b1; inst_addr = 32'h1c00_0040;
      @(negedge clk);
      check("lock_c0_bus_addr", bus_addr, 32'h1c00_0040);
      tick();
      data_req = 1'b1; data_addr = 32'h1c00_0200;
      for (int c = 1; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("lock_c%0d_bus_addr", c), bus_addr, 32'h1c00_0040);
         check($sformatf("lock_c%0d_data_ok", c), {data_addr_ok, inst_addr_ok}, 0);
         tick();
      end
      bus_addr_ok = 1'b1;
      @(negedge clk);
      check("lock_acc_inst", inst_addr_ok, 1);
      check("lock_acc_data", data_addr_ok, 0);
      check("lock_acc_addr", bus_addr, 32'h1c00_0040);
      if (inst_addr_ok) exp_q.push_back(OWNER_INST);
      tick();
      inst_req = 1'b0;
      @(negedge clk);
      check("lock_next_data", data_addr_ok, 1);
      check("lock_next_addr", bus_addr, 32'h1c00_0200);
      if (data_addr_ok) exp_q.push_back(OWNER_DATA);
      tick();
      data_req = 1'b0;

      // Full: two outstanding, third request held off.
      inst_req = 1'b1; inst_addr = 32'h1c00_0080;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("full_c%0d_bus_req", c), bus_req, 0);
         check($sformatf("full_c%0d_addr_ok", c), {inst_addr_ok, data_addr_ok}, 0);
         tick();
      end
      bus_data_ok = 1'b1; bus_rdata = 32'h1111_0000;
      @(negedge clk);
      check("full_pop_bus_req", bus_req, 0);
      rsp_check("full_pop", 32'h1111_0000);
      tick();
      bus_data_ok = 1'b0;
      @(negedge clk);
      check("full_release_req", bus_req, 1);
      check("full_release_ok", inst_addr_ok, 1);
      if (inst_addr_ok) exp_q.push_back(OWNER_INST);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'h2222_0000;
      @(negedge clk);
      rsp_check("drain1", 32'h2222_0000);
      tick();
      // Push and pop together at count 1.
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1c00_0400;
      data_wstrb = 4'hf; data_wdata = 32'hcafe_f00d;
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h3333_0000;
      @(negedge clk);
      check("pp_data_addr_ok", data_addr_ok, 1);
      check("pp_bus_wr", bus_wr, 1);
      check("pp_bus_wdata", bus_wdata, 32'hcafe_f00d);
      rsp_check("pp", 32'h3333_0000);
      if (data_addr_ok) exp_q.push_back(OWNER_DATA);
      tick();
      data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; bus_data_ok = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h1c00_00c0;
      @(negedge clk);
      check("pp_count1_accept", inst_addr_ok, 1);
      if (inst_addr_ok) exp_q.push_back(OWNER_INST);
      tick();
      inst_req = 1'b0;
      data_req = 1'b1; data_addr = 32'h1c00_0500;
      @(negedge clk);
      check("pp_count2_block", {bus_req, data_addr_ok}, 0);
      tick();
      data_req = 1'b0; bus_addr_ok = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'h0;
      @(negedge clk);
      rsp_check("wr_rsp", 32'h0);
      tick();
      bus_rdata = 32'h4444_0000;
      @(negedge clk);
      rsp_check("drain2", 32'h4444_0000);
      tick();

      // Spurious response with nothing outstanding.
      bus_rdata = 32'hdead_beef;
      @(negedge clk);
      check("spur_no_data_ok", {inst_data_ok, data_data_ok}, 0);
      tick();
      bus_data_ok = 1'b0;
      @(negedge clk);
      check("spur_set", spurious_rsp, 1);
      tick(); tick();
      @(negedge clk);
      check("spur_sticky", spurious_rsp, 1);
      tick();
      inst_req = 1'b1; inst_addr = 32'h1c00_0004; bus_addr_ok = 1'b1;
      @(negedge clk);
      check("spur_then_issue", inst_addr_ok, 1);
      if (inst_addr_ok) exp_q.push_back(OWNER_INST);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'h5555_0001;
      @(negedge clk);
      rsp_check("spur_then_rsp", 32'h5555_0001);
      tick();
      bus_data_ok = 1'b0;

      // Reset with two outstanding.
      data_req = 1'b1; data_addr = 32'h1c00_0300;
      inst_req = 1'b1; inst_addr = 32'h1c00_0010; bus_addr_ok = 1'b1;
      @(negedge clk);
      check("mid_issue_data", data_addr_ok, 1);
      tick();
      data_req = 1'b0;
      @(negedge clk);
      check("mid_issue_inst", inst_addr_ok, 1);
      tick();
      reset = 1'b1;
      data_req = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h7777_7777;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      tick(); tick();
      idle();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mid_post_spur", spurious_rsp, 0);
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'h5a5a_5a5a;
      @(negedge clk);
      check("mid_late_rsp", {inst_data_ok, data_data_ok}, 0);
      tick();
      bus_data_ok = 1'b0;
      @(negedge clk);
      check("mid_late_spur", spurious_rsp, 1);
      tick();
      inst_req = 1'b1; inst_addr = 32'h1c00_0020; bus_addr_ok = 1'b1;
      @(negedge clk);
      check("mid_new_req", bus_req, 1);
      check("mid_new_addr_ok", inst_addr_ok, 1);
      if (inst_addr_ok) exp_q.push_back(OWNER_INST);
      tick();
      inst_req = 1'b0; bus_addr_ok = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'h0bad_cafe;
      @(negedge clk);
      rsp_check("mid_new_rsp", 32'h0bad_cafe);
      tick();
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
